// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: MIPS32 instruction fetch with boot cycle, branch redirect/flush, stall and halt.
module pc_fetch_stage #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] npc_in,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_npc,
  output logic              if_id_valid,
  output logic              halted,
  output logic              misalign_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [ADDR_W-1:0] BOOT_NPC = RESET_PC + ADDR_W'(4);
  state_t state;
  logic [ADDR_W-1:0] redir_pc;
  logic is_halt;
  assign redir_pc = {branch_target[ADDR_W-1:2], 2'b00};
  assign is_halt = imem_data[DATA_W-1:DATA_W-6] == HALT_OPCODE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc_out       <= RESET_PC;
      if_id_instr  <= NOP_INSTR;
      if_id_npc    <= '0;
      if_id_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else if (state == BOOT) begin
      // npc_in is stale until the adder has seen a PC change, so use the internal +4
      if (!stall) begin
        if_id_instr <= imem_data;
        if_id_npc   <= BOOT_NPC;
        if_id_valid <= 1'b1;
        pc_out      <= BOOT_NPC;
        state       <= RUN;
      end
    end else if (branch_taken) begin
      pc_out      <= redir_pc;
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      state       <= RUN;
      if (branch_target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (!stall) begin
      if (state == HALT) begin
        if_id_instr <= NOP_INSTR;
        if_id_npc   <= '0;
        if_id_valid <= 1'b0;
      end else begin
        if_id_instr <= imem_data;
        if_id_npc   <= npc_in;
        if_id_valid <= 1'b1;
        pc_out      <= is_halt ? pc_out : npc_in;
        halted      <= is_halt;
        state       <= is_halt ? HALT : RUN;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed checks of boot, fetch, stall, branch, misalign, halt, wrap and async reset.
module tb_pc_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] npc_in;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        stall;
  logic [11:0] pc_out;
  logic [31:0] if_id_instr;
  logic [11:0] if_id_npc;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  int total = 0;
  int bad = 0;

  pc_fetch_stage dut (
    .clk(clk), .rst(rst), .npc_in(npc_in), .imem_data(imem_data),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .pc_out(pc_out), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;
  assign npc_in = pc_out + 12'd4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] pc, input logic [31:0] ins,
                         input logic [11:0] npc, input logic v, input logic h, input logic m);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".npc"}, 32'(if_id_npc), 32'(npc));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".mis"}, 32'(misalign_err), 32'(m));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_data = 32'h2001_0005;
    #2 chk_all("reset", 12'h000, 0, 12'h000, 0, 0, 0);
    #10 rst = 1'b0;
    stall = 1'b1;
    step();
    chk_all("boot_stall", 12'h000, 0, 12'h000, 0, 0, 0);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 12'h040;
    step();
    chk_all("boot", 12'h004, 32'h2001_0005, 12'h004, 1, 0, 0);
    branch_taken = 1'b0;
    imem_data = 32'h1111_1111; step();
    chk_all("seq1", 12'h008, 32'h1111_1111, 12'h008, 1, 0, 0);
    imem_data = 32'h2222_2222; step();
    chk_all("seq2", 12'h00C, 32'h2222_2222, 12'h00C, 1, 0, 0);
    imem_data = 32'h3333_3333; step();
    chk_all("seq3", 12'h010, 32'h3333_3333, 12'h010, 1, 0, 0);
    stall = 1'b1; imem_data = 32'h4444_4444;
    step();
    chk_all("stall1", 12'h010, 32'h3333_3333, 12'h010, 1, 0, 0);
    step();
    chk_all("stall2", 12'h010, 32'h3333_3333, 12'h010, 1, 0, 0);
    branch_taken = 1'b1; branch_target = 12'h040; step();
    chk_all("br_over_stall", 12'h040, 0, 12'h000, 0, 0, 0);
    branch_taken = 1'b0; stall = 1'b0; imem_data = 32'h5555_5555; step();
    chk_all("target_fetch", 12'h044, 32'h5555_5555, 12'h044, 1, 0, 0);
    branch_taken = 1'b1; branch_target = 12'h046; step();
    chk_all("misalign", 12'h044, 0, 12'h000, 0, 0, 1);
    branch_target = 12'h020; step();
    chk_all("mis_sticky", 12'h020, 0, 12'h000, 0, 0, 1);
    branch_taken = 1'b0; imem_data = 32'hFC00_0000; step();
    chk_all("halt_in", 12'h020, 32'hFC00_0000, 12'h024, 1, 1, 1);
    imem_data = 32'h6666_6666; step();
    chk_all("halt_bubble", 12'h020, 0, 12'h000, 0, 1, 1);
    stall = 1'b1; step();
    chk_all("halt_stall", 12'h020, 0, 12'h000, 0, 1, 1);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 12'h080; step();
    chk_all("halt_squash", 12'h080, 0, 12'h000, 0, 0, 1);
    imem_data = 32'h7777_7777; branch_taken = 1'b0; step();
    chk_all("after_halt", 12'h084, 32'h7777_7777, 12'h084, 1, 0, 1);
    branch_taken = 1'b1; branch_target = 12'hFFC; step();
    chk_all("to_ffc", 12'hFFC, 0, 12'h000, 0, 0, 1);
    branch_taken = 1'b0; imem_data = 32'h8888_8888; step();
    chk_all("wrap", 12'h000, 32'h8888_8888, 12'h000, 1, 0, 1);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 12'h100;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 12'h000, 0, 12'h000, 0, 0, 0);
    #1 rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_data = 32'h9999_9999;
    step();
    chk_all("reboot", 12'h004, 32'h9999_9999, 12'h004, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
